// File: rtl/serial_word_tx.sv
// Parallel-in/serial-out word transmitter: loads one word on a LOAD handshake and
// shifts it out one bit per SER_EN tick, framed by FRAME. Define SERIAL_WORD_TX_PARITY_EN
// to append an odd-parity bit after the last data bit.
module serial_word_tx #(
  parameter int WORD_WIDTH        = 32,
  parameter bit LSB_FIRST         = 1'b1,
  parameter int PROPAGATION_DELAY = 18
) (
  input  logic                  CLK,
  input  logic                  CLR_n,
  input  logic                  LOAD,
  input  logic [WORD_WIDTH-1:0] D,
  input  logic                  SER_EN,
  output logic                  Q,
  output logic                  FRAME,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int CNT_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_WIDTH - 1);

  // The TTL delay figure only matters to the behavioural timing model; here it is sanity-checked.
  if (WORD_WIDTH < 2 || PROPAGATION_DELAY < 0) begin : g_bad_params
    $error("serial_word_tx: WORD_WIDTH must be >= 2 and PROPAGATION_DELAY >= 0");
  end

`ifdef SERIAL_WORD_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
  logic parity_bit;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t                state;
  logic [WORD_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  q_reg;
  logic                  frame_reg;
  logic                  busy_reg;
  logic                  done_reg;

  logic                  first_bit;
  logic                  next_bit;
  logic [WORD_WIDTH-1:0] shifted;

  // The bit on Q always comes from the end of shift_reg facing the output.
  assign first_bit = LSB_FIRST ? D[0] : D[WORD_WIDTH-1];
  assign next_bit  = LSB_FIRST ? shift_reg[1] : shift_reg[WORD_WIDTH-2];
  assign shifted   = LSB_FIRST ? (shift_reg >> 1) : (shift_reg << 1);

  always_ff @(posedge CLK) begin
    if (!CLR_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      q_reg     <= 1'b0;
      frame_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
`ifdef SERIAL_WORD_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (LOAD) begin
            shift_reg <= D;
            q_reg     <= first_bit;
            frame_reg <= 1'b1;
            busy_reg  <= 1'b1;
            bit_cnt   <= '0;
            state     <= SHIFT;
`ifdef SERIAL_WORD_TX_PARITY_EN
            parity_bit <= ~^D;
`endif
          end
        end
        SHIFT: begin
          if (SER_EN) begin
            if (bit_cnt != LAST_BIT) begin
              q_reg     <= next_bit;
              shift_reg <= shifted;
              bit_cnt   <= bit_cnt + CNT_W'(1);
            end else begin
`ifdef SERIAL_WORD_TX_PARITY_EN
              q_reg <= parity_bit;
              state <= PARITY;
`else
              q_reg     <= 1'b0;
              frame_reg <= 1'b0;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state     <= IDLE;
`endif
            end
          end
        end
`ifdef SERIAL_WORD_TX_PARITY_EN
        PARITY: begin
          if (SER_EN) begin
            q_reg     <= 1'b0;
            frame_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state     <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign Q     = q_reg;
  assign FRAME = frame_reg;
  assign BUSY  = busy_reg;
  assign DONE  = done_reg;

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed bench for serial_word_tx (32-bit, LSB first); follows SERIAL_WORD_TX_PARITY_EN
// when the build defines it.
module tb_serial_word_tx;

`ifdef SERIAL_WORD_TX_PARITY_EN
  localparam int NB = 33;
  localparam logic [31:0] WORD_B = 32'h3;
`else
  localparam int NB = 32;
  localparam logic [31:0] WORD_B = 32'h2;
`endif

  logic        CLK = 1'b0;
  logic        CLR_n;
  logic        LOAD;
  logic [31:0] D;
  logic        SER_EN;
  logic        Q, FRAME, BUSY, DONE;

  int checks = 0;
  int errors = 0;
  int frame_cycles;

  serial_word_tx #(.WORD_WIDTH(32), .LSB_FIRST(1'b1), .PROPAGATION_DELAY(18)) dut (
    .CLK(CLK), .CLR_n(CLR_n), .LOAD(LOAD), .D(D), .SER_EN(SER_EN),
    .Q(Q), .FRAME(FRAME), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  function automatic logic exp_bit(input logic [31:0] w, input int k);
    if (k < 32) return w[k];
    return ~^w;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check_output({tag, ".Q"}, 32'(Q), 32'd0);
    check_output({tag, ".FRAME"}, 32'(FRAME), 32'd0);
    check_output({tag, ".BUSY"}, 32'(BUSY), 32'd0);
    check_output({tag, ".DONE"}, 32'(DONE), 32'd0);
  endtask

  task automatic check_done(input string tag);
    check_output({tag, ".done"}, 32'(DONE), 32'd1);
    check_output({tag, ".frame_end"}, 32'(FRAME), 32'd0);
    check_output({tag, ".busy_end"}, 32'(BUSY), 32'd0);
    check_output({tag, ".q_end"}, 32'(Q), 32'd0);
  endtask

  // Loads one word with SER_EN high every cycle and checks every bit time plus the DONE pulse.
  task automatic apply_stimulus(input logic [31:0] word, input string tag);
    LOAD = 1'b1; D = word; SER_EN = 1'b1;
    step();
    LOAD = 1'b0; D = ~word;
    check_output({tag, ".bit0"}, 32'(Q), 32'(exp_bit(word, 0)));
    check_output({tag, ".frame_start"}, 32'(FRAME), 32'd1);
    check_output({tag, ".busy_start"}, 32'(BUSY), 32'd1);
    for (int k = 1; k < NB; k++) begin
      step();
      check_output($sformatf("%s.bit%0d", tag, k), 32'(Q), 32'(exp_bit(word, k)));
      check_output($sformatf("%s.frame%0d", tag, k), 32'(FRAME), 32'd1);
      check_output($sformatf("%s.nodone%0d", tag, k), 32'(DONE), 32'd0);
    end
    step();
    check_done(tag);
    step();
    check_output({tag, ".done_clear"}, 32'(DONE), 32'd0);
  endtask

  initial begin
    CLR_n = 1'b0; LOAD = 1'b1; SER_EN = 1'b1; D = 32'hDEAD_BEEF;

    $display("[TB] test 1: reset with LOAD and SER_EN high");
    step();
    check_idle("rst1");
    step();
    check_idle("rst2");
    CLR_n = 1'b1; LOAD = 1'b0;
    step();
    check_idle("rst_release");

    $display("[TB] test 2: A5A5_0F0F with SER_EN every cycle");
    apply_stimulus(32'hA5A5_0F0F, "t2");

    $display("[TB] test 3: SER_EN one cycle in four");
    frame_cycles = 0;
    LOAD = 1'b1; D = 32'h8000_0001; SER_EN = 1'b0;
    step();
    LOAD = 1'b0; D = 32'h0;
    check_output("t3.bit0", 32'(Q), 32'd1);
    if (FRAME) frame_cycles++;
    for (int k = 0; k < NB; k++) begin
      for (int h = 0; h < 3; h++) begin
        SER_EN = 1'b0;
        step();
        check_output($sformatf("t3.hold%0d_%0d", k, h), 32'(Q), 32'(exp_bit(32'h8000_0001, k)));
        if (FRAME) frame_cycles++;
      end
      SER_EN = 1'b1;
      step();
      if (k < NB - 1) begin
        check_output($sformatf("t3.bit%0d", k + 1), 32'(Q), 32'(exp_bit(32'h8000_0001, k + 1)));
        if (FRAME) frame_cycles++;
      end else begin
        check_done("t3");
      end
    end
    SER_EN = 1'b0;
    check_output("t3.frame_len", 32'(frame_cycles), 32'(NB * 4));
    step();
    check_output("t3.done_clear", 32'(DONE), 32'd0);

    $display("[TB] test 4: LOAD while busy is ignored");
    LOAD = 1'b1; D = 32'h0; SER_EN = 1'b1;
    step();
    LOAD = 1'b0;
    check_output("t4.bit0", 32'(Q), 32'd0);
    for (int k = 1; k < NB; k++) begin
      if (k == 10) begin
        LOAD = 1'b1; D = 32'hFFFF_FFFF;
      end else begin
        LOAD = 1'b0;
      end
      step();
      check_output($sformatf("t4.bit%0d", k), 32'(Q), 32'(exp_bit(32'h0, k)));
    end
    LOAD = 1'b0;
    step();
    check_done("t4");
    for (int i = 0; i < 3; i++) begin
      step();
      check_output($sformatf("t4.no_second_done%0d", i), 32'(DONE), 32'd0);
      check_output($sformatf("t4.no_queue%0d", i), 32'(BUSY), 32'd0);
    end

    $display("[TB] test 5: reset mid-frame then fresh frame");
    LOAD = 1'b1; D = 32'hA5A5_0F0F; SER_EN = 1'b1;
    step();
    LOAD = 1'b0;
    for (int k = 1; k <= 16; k++) step();
    check_output("t5.bit16", 32'(Q), 32'(exp_bit(32'hA5A5_0F0F, 16)));
    check_output("t5.busy_mid", 32'(BUSY), 32'd1);
    CLR_n = 1'b0;
    step();
    check_idle("t5.rst");
    CLR_n = 1'b1;
    step();
    check_idle("t5.after_rst");
    apply_stimulus(32'h1234_5678, "t5");

    $display("[TB] test 6: back-to-back frames with LOAD held");
    LOAD = 1'b1; D = 32'h1; SER_EN = 1'b1;
    step();
    D = WORD_B;
    check_output("t6a.bit0", 32'(Q), 32'd1);
    for (int k = 1; k < NB; k++) begin
      step();
      check_output($sformatf("t6a.bit%0d", k), 32'(Q), 32'(exp_bit(32'h1, k)));
    end
    step();
    check_done("t6a");
    step();
    LOAD = 1'b0; D = 32'h0;
    check_output("t6b.frame_restart", 32'(FRAME), 32'd1);
    check_output("t6b.busy_restart", 32'(BUSY), 32'd1);
    check_output("t6b.done_clear", 32'(DONE), 32'd0);
    check_output("t6b.bit0", 32'(Q), 32'(exp_bit(WORD_B, 0)));
    for (int k = 1; k < NB; k++) begin
      step();
      check_output($sformatf("t6b.bit%0d", k), 32'(Q), 32'(exp_bit(WORD_B, k)));
    end
    step();
    check_done("t6b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
